// File: rtl/power_integrator.sv
// Power integrator: sums or peak-holds a block of power samples
// and emits one shifted, saturated result per finished block.
module power_integrator #(
  parameter int IN_WIDTH  = 95,
  parameter int CNT_WIDTH = 10,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 peak_detect,
  input  logic [CNT_WIDTH-1:0] num_integr,
  input  logic [5:0]           shift,
  input  logic                 clear,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int AW = IN_WIDTH + CNT_WIDTH;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        sample;
  logic [AW-1:0]        shifted;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [5:0]           shift_q, shift_d;
  logic                 peak_q, peak_d;
  logic                 start;
  logic                 fin;
  logic [OUT_WIDTH-1:0] res;

  assign busy = (state_q == ACCUM);

  // Next-state, accumulator update and block-finish detection
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    num_d   = num_q;
    shift_d = shift_q;
    fin     = 1'b0;
    sample  = {{CNT_WIDTH{1'b0}}, in_data};
    cnt_inc = cnt_q + CNT_WIDTH'(1);
    target  = (num_q == '0) ? CNT_WIDTH'(1) : num_q;
    start   = in_valid && ((state_q == IDLE) || clear);
    if (start) begin
      peak_d  = peak_detect;
      num_d   = num_integr;
      shift_d = shift;
      acc_d   = sample;
      cnt_d   = CNT_WIDTH'(1);
      state_d = ACCUM;
      if (num_integr <= CNT_WIDTH'(1)) begin
        fin     = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (clear && (state_q == ACCUM)) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if ((state_q == ACCUM) && in_valid) begin
      if (peak_q)
        acc_d = (sample > acc_q) ? sample : acc_q;
      else
        acc_d = acc_q + sample;
      cnt_d = cnt_inc;
      if (cnt_inc == target) begin
        fin     = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Result formatting: shift in sum mode, then saturate
  always_comb begin
    shifted = peak_d ? acc_d : (acc_d >> shift_d);
    if (|shifted[AW-1:OUT_WIDTH])
      res = {OUT_WIDTH{1'b1}};
    else
      res = shifted[OUT_WIDTH-1:0];
  end

  // State, shadow config and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      peak_q    <= 1'b0;
      num_q     <= '0;
      shift_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      peak_q    <= peak_d;
      num_q     <= num_d;
      shift_q   <= shift_d;
      out_valid <= fin;
      if (fin)
        out_data <= res;
    end
  end

endmodule

// File: tb/tb_power_integrator.sv
// Bench for power_integrator: directed block scenarios plus
// randomized traffic against a sample-list reference model.
module tb_power_integrator;

  localparam int IW = 95;
  localparam int CW = 10;
  localparam int OW = 64;
  localparam int AW = IW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clken = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          peak_detect = 1'b0;
  logic [CW-1:0] num_integr = '0;
  logic [5:0]    shift = '0;
  logic          clear = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  power_integrator #(
    .IN_WIDTH(IW),
    .CNT_WIDTH(CW),
    .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clken(clken),
    .in_valid(in_valid),
    .in_data(in_data),
    .peak_detect(peak_detect),
    .num_integr(num_integr),
    .shift(shift),
    .clear(clear),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy)
  );

  task automatic check(input string nm,
                       input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: the block is just the list of accepted samples
  logic [IW-1:0] blk[$];
  bit            m_peak = 1'b0;
  int            m_n = 1;
  int            m_shift = 0;
  logic          exp_valid = 1'b0;
  logic [OW-1:0] exp_data = '0;
  bit            last_en = 1'b0;
  bit            started = 1'b0;
  int            n_valid = 0;
  int            n_busy = 0;
  logic [OW-1:0] last_out = '0;

  function automatic logic [OW-1:0] block_result();
    logic [AW-1:0] s;
    s = '0;
    foreach (blk[i]) begin
      if (m_peak) begin
        if (AW'(blk[i]) > s) s = AW'(blk[i]);
      end else begin
        s = s + AW'(blk[i]);
      end
    end
    if (!m_peak) s = s >> m_shift;
    if (|s[AW-1:OW]) return {OW{1'b1}};
    return s[OW-1:0];
  endfunction

  initial begin : model
    forever begin
      @(posedge clk);
      last_en = rst || clken;
      if (rst) begin
        started = 1'b1;
        blk.delete();
        exp_valid = 1'b0;
        exp_data = '0;
      end else if (clken) begin
        exp_valid = 1'b0;
        if (clear) blk.delete();
        if (in_valid) begin
          if (blk.size() == 0) begin
            m_peak = peak_detect;
            m_n = (num_integr == '0) ? 1 : int'(num_integr);
            m_shift = int'(shift);
          end
          blk.push_back(in_data);
          if (blk.size() == m_n) begin
            exp_data = block_result();
            exp_valid = 1'b1;
            blk.delete();
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        check("out_valid", OW'(out_valid), OW'(exp_valid));
        check("busy", OW'(busy), OW'(blk.size() != 0));
        check("out_data", out_data, exp_data);
        if (last_en && out_valid) begin
          n_valid++;
          last_out = out_data;
        end
        if (last_en && busy) n_busy++;
      end
    end
  end

  task automatic tick(input bit r, input bit en, input bit v,
                      input logic [IW-1:0] d, input bit clr);
    @(negedge clk);
    #1;
    rst = r;
    clken = en;
    in_valid = v;
    in_data = d;
    clear = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, '0, 0);
  endtask

  task automatic cfg(input bit pk, input int n, input int sh);
    peak_detect = pk;
    num_integr = CW'(n);
    shift = 6'(sh);
  endtask

  int v0;
  int b0;
  logic [IW-1:0] big;
  logic [IW-1:0] rd;

  initial begin : stim
    big = '0;
    big[94] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", OW'(out_valid), '0);
    check("rst_busy", OW'(busy), '0);

    // sum block 10,20,30,40
    cfg(0, 4, 0);
    v0 = n_valid;
    b0 = n_busy;
    tick(0, 1, 1, IW'(10), 0);
    tick(0, 1, 1, IW'(20), 0);
    tick(0, 1, 1, IW'(30), 0);
    tick(0, 1, 1, IW'(40), 0);
    tick(0, 1, 0, '0, 0);
    check("sum_latency_valid", OW'(out_valid), OW'(1));
    check("sum_data", out_data, OW'(100));
    idle(3);
    check("sum_valid_count", OW'(n_valid - v0), OW'(1));
    check("sum_busy_cycles", OW'(n_busy - b0), OW'(3));

    // peak block, then single-sample block with count 0
    cfg(1, 3, 0);
    tick(0, 1, 1, IW'(7), 0);
    tick(0, 1, 1, IW'(42), 0);
    tick(0, 1, 1, IW'(5), 0);
    tick(0, 1, 0, '0, 0);
    check("peak_data", out_data, OW'(42));
    cfg(1, 0, 0);
    tick(0, 1, 1, IW'(9), 0);
    tick(0, 1, 0, '0, 0);
    check("cnt0_valid", OW'(out_valid), OW'(1));
    check("cnt0_data", out_data, OW'(9));
    idle(2);

    // saturation and shift
    cfg(0, 2, 0);
    tick(0, 1, 1, big, 0);
    tick(0, 1, 1, big, 0);
    tick(0, 1, 0, '0, 0);
    check("sat_data", out_data, {OW{1'b1}});
    cfg(0, 2, 41);
    tick(0, 1, 1, big, 0);
    tick(0, 1, 1, big, 0);
    tick(0, 1, 0, '0, 0);
    check("shift41_data", out_data, OW'(1) << 54);
    idle(2);

    // clken gaps, bubbles, ignored mid-block config change
    cfg(0, 3, 0);
    v0 = n_valid;
    tick(0, 1, 1, IW'(1), 0);
    tick(0, 0, 1, IW'(77), 0);
    tick(0, 1, 0, '0, 0);
    cfg(1, 1, 5);
    tick(0, 0, 0, '0, 0);
    tick(0, 1, 1, IW'(2), 0);
    tick(0, 0, 1, IW'(99), 0);
    tick(0, 1, 1, IW'(3), 0);
    tick(0, 0, 0, '0, 0);
    check("gap_valid", OW'(out_valid), OW'(1));
    tick(0, 0, 0, '0, 0);
    check("gap_valid_held", OW'(out_valid), OW'(1));
    idle(3);
    check("gap_data", last_out, OW'(6));
    check("gap_valid_count", OW'(n_valid - v0), OW'(1));

    // clear with a sample restarts the block
    cfg(0, 4, 0);
    v0 = n_valid;
    tick(0, 1, 1, IW'(5), 0);
    tick(0, 1, 1, IW'(5), 0);
    tick(0, 1, 1, IW'(5), 1);
    tick(0, 1, 1, IW'(5), 0);
    tick(0, 1, 1, IW'(5), 0);
    tick(0, 1, 1, IW'(5), 0);
    idle(3);
    check("clear_data", last_out, OW'(20));
    check("clear_valid_count", OW'(n_valid - v0), OW'(1));

    // reset mid-block
    v0 = n_valid;
    tick(0, 1, 1, IW'(5), 0);
    tick(0, 1, 1, IW'(5), 0);
    tick(1, 0, 1, IW'(5), 1);
    tick(1, 1, 0, '0, 0);
    tick(0, 1, 0, '0, 0);
    check("midrst_out_data", out_data, '0);
    check("midrst_busy", OW'(busy), '0);
    idle(3);
    check("midrst_valid_count", OW'(n_valid - v0), '0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0)
          cfg(1'($urandom_range(0, 1)), $urandom_range(0, 40),
              $urandom_range(0, 41));
        else
          cfg(1'($urandom_range(0, 1)), $urandom_range(0, 5),
              $urandom_range(0, 41));
      end
      case ($urandom_range(0, 2))
        0: rd = IW'($urandom_range(0, 255));
        1: rd = IW'({$urandom, $urandom});
        default: rd = IW'({$urandom, $urandom, $urandom});
      endcase
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 6),
           rd,
           ($urandom_range(0, 19) == 0));
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/power_integrator.md
POWER_INTEGRATOR -- requirements
Module: power_integrator

Interface
REQ-001 Parameter IN_WIDTH, default 95, width of the unsigned power sample produced by the upstream squaring stage.
REQ-002 Parameter CNT_WIDTH, default 10, width of the integration-count configuration field.
REQ-003 Parameter OUT_WIDTH, default 64, width of the integrated result.
REQ-004 Port clk, input, 1, single clock; all logic is synchronous to its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port clken, input, 1, clock enable; no state changes when low.
REQ-007 Port in_valid, input, 1, in_data holds a sample this cycle.
REQ-008 Port in_data, input, IN_WIDTH, unsigned power sample.
REQ-009 Port peak_detect, input, 1, 0 = sum mode, 1 = max-hold mode.
REQ-010 Port num_integr, input, CNT_WIDTH, samples per block (0 treated as 1).
REQ-011 Port shift, input, 6, right shift applied to the sum before output (0..IN_WIDTH+CNT_WIDTH-OUT_WIDTH).
REQ-012 Port clear, input, 1, abandon the current block.
REQ-013 Port out_data, output, OUT_WIDTH, integrated result.
REQ-014 Port out_valid, output, 1, one-cycle strobe when out_data is new.
REQ-015 Port busy, output, 1, a block is partially accumulated.

Function
REQ-016 All state updates (accumulator, counter, FSM, outputs) occur only on rising edges with clken=1; with clken=0 every register holds and out_valid holds its value.
REQ-017 FSM states: IDLE (no sample in block) and ACCUM; busy=1 exactly in ACCUM.
REQ-018 IDLE + in_valid: latch peak_detect, num_integr, shift into shadow registers; acc <= zero-extended in_data; cnt <= 1; go to ACCUM, unless the effective count is 1 (then finish per REQ-021 and stay in IDLE).
REQ-019 Configuration inputs are ignored while in ACCUM; changes take effect at the next block start.
REQ-020 ACCUM + in_valid: sum mode acc <= acc + in_data; peak mode acc <= max(acc, in_data) (ties keep acc); cnt <= cnt + 1.
REQ-021 Block finishes on the sample where cnt reaches the latched count: FSM to IDLE, cnt <= 0, out_valid <= 1 on the next enabled edge with out_data computed from the final acc including that sample.
REQ-022 Latency: out_valid/out_data appear exactly one enabled cycle after the last sample of the block is accepted.
REQ-023 acc width IN_WIDTH+CNT_WIDTH (105 default); sum mode cannot overflow.
REQ-024 Sum mode: out_data = acc >> latched shift, saturated to 2^OUT_WIDTH-1 if any higher bit is set.
REQ-025 Peak mode: shift is ignored; out_data = acc saturated to 2^OUT_WIDTH-1.
REQ-026 out_valid is high for exactly one enabled cycle per finished block; out_data holds its value until the next finished block.
REQ-027 ACCUM + in_valid=0: no change.
REQ-028 clear=1 discards acc and cnt, returns to IDLE, no out_valid for the discarded block; if in_valid=1 in the same cycle, that sample starts a new block per REQ-018 with current configuration.
REQ-029 clear in IDLE with in_valid=0 has no effect.

Reset
REQ-030 rst=1 (sampled regardless of clken) forces IDLE, acc=0, cnt=0, shadow config=0, out_data=0, out_valid=0, busy=0; reset takes priority over clear and in_valid.
REQ-031 Reset mid-block discards the block without emitting out_valid.

Verification
REQ-032 Sum: num_integr=4, shift=0, peak_detect=0, samples 10,20,30,40 continuous -> one out_valid one cycle after the 4th sample, out_data=100, busy high for 3 cycles.
REQ-033 Peak: num_integr=3, peak_detect=1, samples 7,42,5 -> out_data=42; num_integr=0 with sample 9 -> out_valid next cycle, out_data=9.
REQ-034 Saturation/shift: num_integr=2, shift=0, samples 2^94,2^94 -> out_data=2^64-1; same with shift=41 -> out_data=2^54.
REQ-035 clken gaps and bubbles: num_integr=3 with clken toggling and in_valid gaps between samples 1,2,3 -> out_data=6, out_valid width exactly one enabled cycle; config change mid-block ignored.
REQ-036 clear with in_valid after 2 of 4 samples (value 5), then 3 more samples of 5 -> single out_valid, out_data=20; rst mid-block -> no out_valid, all outputs 0.
